// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared constants and the buffered fetch entry type
package inst_fetch_pkg;
    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [INST_W-1:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [INST_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_fifo.sv
// fetch_fifo: instruction buffer with synchronous flush and simultaneous push/pop
module fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t mem_q [DEPTH];
    fetch_entry_t mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic do_push, do_pop;

    // Pointer/count update; a pop frees the slot a same-cycle push needs when full, flush overrides both
    always_comb begin
        empty = count_q == '0;
        full = count_q == CW'(DEPTH);
        count = count_q;
        head = mem_q[rd_q];
        do_pop = pop && !empty;
        do_push = push && (!full || do_pop);
        mem_d = mem_q;
        wr_d = wr_q;
        rd_d = rd_q;
        count_d = count_q;
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = push_data;
                wr_d = wr_q + 1'b1;
            end
            if (do_pop) rd_d = rd_q + 1'b1;
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wr_q <= '0;
            rd_q <= '0;
            count_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC, credit-limited imem fetch, redirect flush and decode-side buffer
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] ip_inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, last_pc_q, last_pc_d, target;
    logic [CW-1:0] out_q, out_d, drop_q, drop_d, fifo_count;
    logic fifo_empty, fifo_full, accept, rsp_live, push, pop;
    fetch_entry_t head, push_entry;

    // Credit-gated requests, response tagging, drop accounting and output muxing
    always_comb begin
        target = redirect_pc & ~32'h3;
        imem_req_valid = rst_n && !redirect_en &&
                         (({1'b0, fifo_count} + {1'b0, out_q}) < (CW + 1)'(FIFO_DEPTH));
        imem_req_addr = pc_q;
        accept = imem_req_valid && imem_req_ready;
        rsp_live = imem_rsp_valid && (out_q != '0);
        push = rsp_live && (drop_q == '0) && !redirect_en;
        inst_valid = !fifo_empty;
        pop = inst_valid && inst_ready && !redirect_en;
        push_entry = '{pc: rsp_pc_q, inst: imem_rsp_data};
        out_d = out_q + CW'(accept) - CW'(rsp_live);
        pc_d = redirect_en ? target : accept ? pc_q + PC_INC : pc_q;
        rsp_pc_d = redirect_en ? target : push ? rsp_pc_q + PC_INC : rsp_pc_q;
        drop_d = redirect_en ? out_d : (rsp_live && drop_q != '0) ? drop_q - 1'b1 : drop_q;
        ip_inst = inst_valid ? head.inst : NOP_INST;
        inst_pc = inst_valid ? head.pc : last_pc_q;
        last_pc_d = inst_pc;
    end

    // PC, response-PC and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            last_pc_q <= RESET_PC;
            out_q <= '0;
            drop_q <= '0;
        end else begin
            pc_q <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            last_pc_q <= last_pc_d;
            out_q <= out_d;
            drop_q <= drop_d;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_en),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    a_rsp_tracked: assert property (@(posedge clk) disable iff (!rst_n) imem_rsp_valid |-> out_q != '0);
    a_push_fits: assert property (@(posedge clk) disable iff (!rst_n) push |-> !fifo_full || pop);
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed scenarios checked against an epoch-tagged transaction model
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam int DEPTH = 2;

    logic clk, rst_n;
    logic imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data;
    logic inst_valid, inst_ready, redirect_en;
    logic [31:0] ip_inst, inst_pc, redirect_pc;

    inst_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .ip_inst        (ip_inst),
        .inst_pc        (inst_pc),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int epoch;
        int due;
    } req_t;

    req_t pend[$];
    fetch_entry_t mq[$];
    int epoch, cyc, lat, n_acc, vectors, miscompares;
    logic [31:0] exp_addr, last_pc;

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Memory: answers accepted requests in order once their latency has elapsed
    always @(posedge clk) begin
        #1;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1;
            imem_rsp_data = mem_fn(pend[0].addr);
        end else begin
            imem_rsp_valid = 0;
            imem_rsp_data = '0;
        end
    end

    // Compare DUT outputs with the model, then advance the model by this cycle's events
    always @(negedge clk) begin : cmp
        logic exp_rv;
        bit fresh;
        req_t r;
        if (rst_n) begin
            fresh = 0;
            exp_rv = !redirect_en && (mq.size() + pend.size() < DEPTH);
            chk("inst_valid", inst_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("ip_inst", ip_inst, mq[0].inst);
                chk("inst_pc", inst_pc, mq[0].pc);
                last_pc = mq[0].pc;
            end else begin
                chk("ip_inst_nop", ip_inst, NOP_INST);
                chk("inst_pc_hold", inst_pc, last_pc);
            end
            chk("req_valid", imem_req_valid, exp_rv);
            if (exp_rv) chk("req_addr", imem_req_addr, exp_addr);
            if (exp_rv && imem_req_ready) begin
                pend.push_back('{exp_addr, epoch, cyc + lat});
                exp_addr += 32'd4;
                n_acc++;
            end
            if (imem_rsp_valid && pend.size() > 0) begin
                r = pend.pop_front();
                fresh = r.epoch == epoch && !redirect_en;
            end
            if (mq.size() != 0 && inst_ready && !redirect_en) void'(mq.pop_front());
            if (fresh) mq.push_back('{pc: r.addr, inst: mem_fn(r.addr)});
            if (redirect_en) begin
                mq.delete();
                epoch++;
                exp_addr = redirect_pc & ~32'h3;
            end
        end
        cyc++;
    end

    task automatic do_reset();
        rst_n = 0;
        redirect_en = 0;
        pend.delete();
        mq.delete();
        epoch = 0;
        exp_addr = 32'h0;
        last_pc = 32'h0;
        n_acc = 0;
        #1;
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_ip_inst", ip_inst, NOP_INST);
        chk("rst_inst_pc", inst_pc, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic wait_valid(string name);
        for (int k = 0; k < 20 && !inst_valid; k++) @(negedge clk);
        chk(name, inst_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1;
        imem_req_ready = 1;
        inst_ready = 1;
        redirect_en = 0;
        redirect_pc = '0;
        imem_rsp_valid = 0;
        imem_rsp_data = '0;
        lat = 1;
        vectors = 0;
        miscompares = 0;
        cyc = 0;
        #1;

        // 1: streaming with 1-cycle memory
        do_reset();
        @(negedge clk);
        chk("t1_req0_valid", imem_req_valid, 1);
        chk("t1_req0_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        chk("t1_req1_addr", imem_req_addr, 32'h4);
        chk("t1_not_yet_valid", inst_valid, 0);
        @(negedge clk);
        chk("t1_first_valid", inst_valid, 1);
        chk("t1_first_inst", ip_inst, 32'hA5A5_0000);
        chk("t1_first_pc", inst_pc, 32'h0);
        @(negedge clk);
        chk("t1_second_inst", ip_inst, 32'hA5A5_0004);
        chk("t1_second_pc", inst_pc, 32'h4);
        repeat (16) @(negedge clk);

        // 2: decode stalled, credit caps fetches at two
        inst_ready = 0;
        do_reset();
        repeat (6) @(negedge clk);
        chk("t2_accepted", n_acc, 2);
        chk("t2_req_blocked", imem_req_valid, 0);
        chk("t2_head_inst", ip_inst, 32'hA5A5_0000);
        @(posedge clk);
        #1 inst_ready = 1;
        @(negedge clk);
        chk("t2_pop0_pc", inst_pc, 32'h0);
        @(negedge clk);
        chk("t2_pop1_pc", inst_pc, 32'h4);
        chk("t2_resume_valid", imem_req_valid, 1);
        chk("t2_resume_addr", imem_req_addr, 32'h8);
        repeat (10) @(negedge clk);

        // 3: redirect with two stale fetches in flight, then back-to-back redirects
        lat = 3;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 begin redirect_en = 1; redirect_pc = 32'h0000_0102; end
        @(negedge clk);
        chk("t3_no_req_redirect", imem_req_valid, 0);
        @(posedge clk);
        #1 redirect_en = 0;
        @(negedge clk);
        chk("t3_credit_held", imem_req_valid, 0);
        chk("t3_addr_aligned", imem_req_addr, 32'h100);
        @(negedge clk);
        chk("t3_req_100", imem_req_valid, 1);
        wait_valid("t3_deliver");
        chk("t3_first_pc", inst_pc, 32'h100);
        chk("t3_first_inst", ip_inst, 32'hA5A5_0100);
        @(posedge clk);
        #1 begin redirect_en = 1; redirect_pc = 32'h300; end
        @(posedge clk);
        #1 redirect_pc = 32'h404;
        @(posedge clk);
        #1 redirect_en = 0;
        wait_valid("t3b_deliver");
        chk("t3b_first_pc", inst_pc, 32'h404);
        chk("t3b_first_inst", ip_inst, 32'hA5A5_0404);
        repeat (8) @(negedge clk);

        // 4: redirect coincides with a response and a pop request
        lat = 1;
        do_reset();
        @(posedge clk);
        @(posedge clk);
        #1 begin redirect_en = 1; redirect_pc = 32'h200; end
        @(negedge clk);
        chk("t4_entry_present", inst_valid, 1);
        chk("t4_entry_pc", inst_pc, 32'h0);
        @(posedge clk);
        #1 redirect_en = 0;
        @(negedge clk);
        chk("t4_flushed", inst_valid, 0);
        chk("t4_nop", ip_inst, NOP_INST);
        chk("t4_req_200", imem_req_addr, 32'h200);
        @(negedge clk);
        @(negedge clk);
        chk("t4_new_valid", inst_valid, 1);
        chk("t4_new_pc", inst_pc, 32'h200);
        repeat (6) @(negedge clk);

        // 5: async reset with the buffer full
        inst_ready = 0;
        do_reset();
        repeat (5) @(negedge clk);
        chk("t5_full_valid", inst_valid, 1);
        @(posedge clk);
        #3;
        inst_ready = 1;
        do_reset();
        @(negedge clk);
        chk("t5_restart_valid", imem_req_valid, 1);
        chk("t5_restart_addr", imem_req_addr, 32'h0);
        repeat (6) @(negedge clk);

        // 6: PC wrap through 2^32
        do_reset();
        redirect_en = 1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        chk("t6_no_req", imem_req_valid, 0);
        @(posedge clk);
        #1 redirect_en = 0;
        @(negedge clk);
        chk("t6_req_top", imem_req_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("t6_req_wrap_valid", imem_req_valid, 1);
        chk("t6_req_wrap", imem_req_addr, 32'h0);
        @(negedge clk);
        chk("t6_inst_top_pc", inst_pc, 32'hFFFF_FFFC);
        chk("t6_inst_top", ip_inst, 32'h5A5A_FFFC);
        @(negedge clk);
        chk("t6_inst_wrap_pc", inst_pc, 32'h0);
        chk("t6_inst_wrap", ip_inst, 32'hA5A5_0000);

        // 7: toggling memory and decode readiness with 2-cycle memory
        lat = 2;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1 begin imem_req_ready = i[0]; inst_ready = (i % 3) != 0; end
        end
        imem_req_ready = 1;
        inst_ready = 1;
        repeat (8) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
